// File: rtl/jt51_pkg.sv
// Shared definitions for the operator CSR write path.
//   slot_t       : 5-bit index of a slot in the 32-slot operator ring
//   OP_GRP_*     : register group, taken from addr[7:5] of an operator register
//   UP_*         : bit positions inside the 11-bit up_op strobe vector
//   op_wr_t      : one buffered host write {group, target slot, data}
package jt51_pkg;

    typedef logic [4:0] slot_t;

    localparam logic [2:0] OP_GRP_DT1_MUL = 3'd2;  // 0x40
    localparam logic [2:0] OP_GRP_TL      = 3'd3;  // 0x60
    localparam logic [2:0] OP_GRP_KS_AR   = 3'd4;  // 0x80
    localparam logic [2:0] OP_GRP_AMS_D1R = 3'd5;  // 0xA0
    localparam logic [2:0] OP_GRP_DT2_D2R = 3'd6;  // 0xC0
    localparam logic [2:0] OP_GRP_D1L_RR  = 3'd7;  // 0xE0

    localparam int UP_DT1   = 0;
    localparam int UP_MUL   = 1;
    localparam int UP_TL    = 2;
    localparam int UP_KS    = 3;
    localparam int UP_AMSEN = 4;
    localparam int UP_DT2   = 5;
    localparam int UP_D1L   = 6;
    localparam int UP_AR    = 7;
    localparam int UP_D1R   = 8;
    localparam int UP_D2R   = 9;
    localparam int UP_RR    = 10;
    localparam int UP_W     = 11;

    typedef struct packed {
        logic [2:0] grp;
        slot_t      target;
        logic [7:0] data;
    } op_wr_t;

endpackage

// File: rtl/jt51_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
//   clk, rst_n : clock, asynchronous active-low clear of pointers/count
//   push, din  : write request and data (ignored while full)
//   pop        : remove head (ignored while empty)
//   dout       : current head entry, valid while !empty
//   full, empty, count : occupancy status
module jt51_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jt51_op_wr_sched.sv
// Operator register write scheduler.
// Host writes to 0x40-0xFF are queued and replayed onto the operator CSR
// bank at the one cen period in which the target slot sits at the ring input.
//   clk, rst_n, cen : clock, async active-low reset, clock enable
//   zero            : with cen, the slot sampled at this edge is slot 31
//   wr, addr, wdata : host write port
//   full, busy      : queue full / work outstanding
//   dout, up_*_op   : data bus and field update strobes to the CSR bank
//   slot            : slot the CSR bank samples at the next cen edge
module jt51_op_wr_sched
    import jt51_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SLOT_OFS = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       busy,
    output logic [7:0] dout,
    output logic       up_dt1_op,
    output logic       up_mul_op,
    output logic       up_tl_op,
    output logic       up_ks_op,
    output logic       up_amsen_op,
    output logic       up_dt2_op,
    output logic       up_d1l_op,
    output logic       up_ar_op,
    output logic       up_d1r_op,
    output logic       up_d2r_op,
    output logic       up_rr_op,
    output slot_t      slot
);

    localparam slot_t OFS = slot_t'(SLOT_OFS % 32);

    function automatic logic [UP_W-1:0] grp_strobes(input logic [2:0] grp);
        logic [UP_W-1:0] v;
        v = '0;
        case (grp)
            OP_GRP_DT1_MUL: begin v[UP_DT1]   = 1'b1; v[UP_MUL] = 1'b1; end
            OP_GRP_TL:      begin v[UP_TL]    = 1'b1;                   end
            OP_GRP_KS_AR:   begin v[UP_KS]    = 1'b1; v[UP_AR]  = 1'b1; end
            OP_GRP_AMS_D1R: begin v[UP_AMSEN] = 1'b1; v[UP_D1R] = 1'b1; end
            OP_GRP_DT2_D2R: begin v[UP_DT2]   = 1'b1; v[UP_D2R] = 1'b1; end
            OP_GRP_D1L_RR:  begin v[UP_D1L]   = 1'b1; v[UP_RR]  = 1'b1; end
            default:        v = '0;
        endcase
        return v;
    endfunction

    op_wr_t                 push_ent;
    op_wr_t                 head;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    slot_t                  slot_nxt;
    logic [UP_W-1:0]        up_op;

    // Acceptance looks only at the current full flag, never at a same-cycle pop.
    assign push     = wr && !full && (addr[7:6] != 2'b00);
    assign push_ent = {addr[7:5], slot_t'(addr[4:0] + OFS), wdata};

    jt51_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_wr_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue when the head targets the slot that will be at the ring input
    // after this edge; the strobes then span exactly the period that ends
    // with the CSR bank sampling that slot.
    assign slot_nxt = zero ? '0 : slot + 5'd1;
    assign pop      = cen && !fifo_empty && (head.target == slot_nxt);

    // ---- issue stage: slot counter, data bus and strobe registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot  <= '0;
            dout  <= '0;
            up_op <= '0;
        end else if (cen) begin
            slot <= slot_nxt;
            if (pop) begin
                dout  <= head.data;
                up_op <= grp_strobes(head.grp);
            end else begin
                up_op <= '0;
            end
        end
    end

    assign busy        = (fifo_count != '0) || (|up_op);
    assign up_dt1_op   = up_op[UP_DT1];
    assign up_mul_op   = up_op[UP_MUL];
    assign up_tl_op    = up_op[UP_TL];
    assign up_ks_op    = up_op[UP_KS];
    assign up_amsen_op = up_op[UP_AMSEN];
    assign up_dt2_op   = up_op[UP_DT2];
    assign up_d1l_op   = up_op[UP_D1L];
    assign up_ar_op    = up_op[UP_AR];
    assign up_d1r_op   = up_op[UP_D1R];
    assign up_d2r_op   = up_op[UP_D2R];
    assign up_rr_op    = up_op[UP_RR];

endmodule

// File: tb/tb_jt51_op_wr_sched.sv
module tb_jt51_op_wr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       full, busy;
    logic [7:0] dout;
    logic       up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op;
    logic       up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op;
    logic [4:0] slot;

    int total = 0;
    int bad   = 0;

    jt51_op_wr_sched #(.DEPTH(4), .SLOT_OFS(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .zero        (zero),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .full        (full),
        .busy        (busy),
        .dout        (dout),
        .up_dt1_op   (up_dt1_op),
        .up_mul_op   (up_mul_op),
        .up_tl_op    (up_tl_op),
        .up_ks_op    (up_ks_op),
        .up_amsen_op (up_amsen_op),
        .up_dt2_op   (up_dt2_op),
        .up_d1l_op   (up_d1l_op),
        .up_ar_op    (up_ar_op),
        .up_d1r_op   (up_d1r_op),
        .up_d2r_op   (up_d2r_op),
        .up_rr_op    (up_rr_op),
        .slot        (slot)
    );

    always #5 clk = ~clk;

    // cen every 4 clk, changed on the falling edge so it is stable at posedge
    bit cen_en = 1'b1;
    int cen_div = 0;
    always @(negedge clk) begin
        cen_div <= (cen_div + 1) % 4;
        cen     <= cen_en && (cen_div == 3);
    end

    int cen_cnt = 0;
    always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

    // strobe vector, bit order chosen by the bench
    logic [10:0] vec;
    assign vec = {up_rr_op, up_d2r_op, up_d1r_op, up_ar_op, up_d1l_op, up_dt2_op,
                  up_amsen_op, up_ks_op, up_tl_op, up_mul_op, up_dt1_op};

    function automatic logic [10:0] exp_vec(input logic [7:0] a);
        case (a[7:5])
            3'd2:    return 11'b000_0000_0011;  // dt1 + mul
            3'd3:    return 11'b000_0000_0100;  // tl
            3'd4:    return 11'b000_1000_1000;  // ks + ar
            3'd5:    return 11'b001_0001_0000;  // amsen + d1r
            3'd6:    return 11'b010_0010_0000;  // dt2 + d2r
            3'd7:    return 11'b100_0100_0000;  // d1l + rr
            default: return 11'b0;
        endcase
    endfunction

    typedef struct {
        logic [10:0] vec;
        logic [7:0]  data;
        logic [4:0]  slot;
    } exp_t;

    exp_t exp_q[$];
    int   issue_log[$];

    // Scoreboard: a cen edge after which strobes are high is an issue.
    always @(posedge clk) begin
        bit   was_cen;
        exp_t e;
        was_cen = cen;
        #1;
        if (was_cen && rst_n && vec != 11'b0) begin
            issue_log.push_back(cen_cnt);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_issue: got vec=%h slot=%0d dout=%h, required no strobe", vec, slot, dout);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (vec !== e.vec) begin
                    bad++; $display("FAIL issue_vec: got %h, required %h", vec, e.vec);
                end
                total++;
                if (dout !== e.data) begin
                    bad++; $display("FAIL issue_data: got %h, required %h", dout, e.data);
                end
                total++;
                if (slot !== e.slot) begin
                    bad++; $display("FAIL issue_slot: got %0d, required %0d", slot, e.slot);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic expect_issue(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.vec = exp_vec(a); e.data = d; e.slot = a[4:0];
        exp_q.push_back(e);
    endtask

    task automatic wait_slot(input logic [4:0] s);
        int n = 0;
        while (slot !== s && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL wait_slot: got %0d, required %0d", slot, s);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1200) begin
            @(negedge clk); n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL %s_drain: pending=%0d, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        tick(3);
        total++; if (slot !== 5'd0)  begin bad++; $display("FAIL rst_slot: got %0d, required 0", slot); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h, required 00", dout); end
        total++; if (vec !== 11'b0)  begin bad++; $display("FAIL rst_strobes: got %h, required 000", vec); end
        total++; if (full !== 1'b0)  begin bad++; $display("FAIL rst_full: got %b, required 0", full); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_issue_timing();
        int n = 0;
        int hold = 0;
        logic [7:0] d0;
        wait_slot(5'd3);
        expect_issue(8'h48, 8'h35);
        write_reg(8'h48, 8'h35);
        while (!(up_dt1_op && up_mul_op) && n < 400) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 400) begin
            bad++; $display("FAIL timing_wait: got no strobe, required dt1+mul");
        end
        d0 = dout;
        while (up_dt1_op && up_mul_op && hold < 10) begin
            hold++; @(negedge clk);
        end
        total++; if (hold != 4) begin bad++; $display("FAIL timing_hold: got %0d clk, required 4", hold); end
        total++; if (d0[6:4] !== 3'd3) begin bad++; $display("FAIL timing_dt1: got %0d, required 3", d0[6:4]); end
        total++; if (d0[3:0] !== 4'd5) begin bad++; $display("FAIL timing_mul: got %0d, required 5", d0[3:0]); end
        drain("timing");
    endtask

    task automatic test_low_addr();
        bit seen = 1'b0;
        write_reg(8'h3F, 8'h11);
        write_reg(8'h1F, 8'h22);
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || vec !== 11'b0 || full !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL low_addr: got activity, required busy=0 and no strobe"); end
    endtask

    task automatic test_burst();
        wait_slot(5'd10);
        issue_log.delete();
        for (int i = 0; i < 4; i++) begin
            expect_issue(8'h60 + 8'(i), 8'h10 + 8'(i));
            write_reg(8'h60 + 8'(i), 8'h10 + 8'(i));
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL burst_full: got %b, required 1", full); end
        write_reg(8'h64, 8'h99);
        drain("burst");
        total++;
        if (issue_log.size() != 4) begin
            bad++; $display("FAIL burst_count: got %0d, required 4", issue_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (issue_log[k+1] - issue_log[k] != 1) begin
                    bad++; $display("FAIL burst_spacing: got %0d, required 1", issue_log[k+1] - issue_log[k]);
                end
            end
        end
        tick(160);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_idle: got busy=%b, required 0", busy); end
    endtask

    task automatic test_wrap();
        wait_slot(5'd20);
        issue_log.delete();
        expect_issue(8'h7F, 8'hA5);
        write_reg(8'h7F, 8'hA5);
        expect_issue(8'h60, 8'h5A);
        write_reg(8'h60, 8'h5A);
        drain("wrap");
        total++;
        if (issue_log.size() != 2) begin
            bad++; $display("FAIL wrap_count: got %0d, required 2", issue_log.size());
        end else if (issue_log[1] - issue_log[0] != 1) begin
            bad++; $display("FAIL wrap_spacing: got %0d, required 1", issue_log[1] - issue_log[0]);
        end
    endtask

    task automatic test_zero_resync();
        int rs = 0;
        int n = 0;
        wait_slot(5'd14);
        expect_issue(8'hF2, 8'h3C);
        write_reg(8'hF2, 8'h3C);
        wait_slot(5'd17);
        issue_log.delete();
        zero = 1'b1;
        do begin
            @(posedge clk); n++;
        end while (!cen && n < 8);
        #1 rs = cen_cnt;
        @(negedge clk);
        zero = 1'b0;
        total++; if (slot !== 5'd0) begin bad++; $display("FAIL zero_slot: got %0d, required 0", slot); end
        drain("zero");
        total++;
        if (issue_log.size() != 1) begin
            bad++; $display("FAIL zero_count: got %0d, required 1", issue_log.size());
        end else if (issue_log[0] - rs != 18) begin
            bad++; $display("FAIL zero_latency: got %0d cen, required 18", issue_log[0] - rs);
        end
    endtask

    task automatic test_cen_hold();
        logic [4:0] s;
        logic [7:0] a;
        int st;
        @(negedge clk);
        cen_en = 1'b0;
        tick(2);
        s = slot;
        a = 8'hA0 | 8'(5'(s + 5'd1));
        expect_issue(a, 8'h77);
        write_reg(a, 8'h77);
        tick(20);
        total++; if (slot !== s) begin bad++; $display("FAIL hold_slot: got %0d, required %0d", slot, s); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b, required 1", busy); end
        total++; if (exp_q.size() != 1) begin bad++; $display("FAIL hold_early: got pending=%0d, required 1", exp_q.size()); end
        issue_log.delete();
        st = cen_cnt;
        cen_en = 1'b1;
        drain("hold");
        total++;
        if (issue_log.size() != 1 || issue_log[0] != st + 1) begin
            bad++; $display("FAIL hold_latency: got %0d issues, required one at first cen", issue_log.size());
        end
    endtask

    task automatic test_back_to_back();
        wait_slot(5'd20);
        expect_issue(8'h88, 8'h11);
        write_reg(8'h88, 8'h11);
        expect_issue(8'h88, 8'h22);
        write_reg(8'h88, 8'h22);
        drain("b2b");
        @(negedge clk);
        total++; if (dout !== 8'h22) begin bad++; $display("FAIL b2b_last: got %h, required 22", dout); end
    endtask

    task automatic test_reset_inflight();
        int n = 0;
        wait_slot(5'd2);
        expect_issue(8'hE7, 8'h81);
        write_reg(8'hE7, 8'h81);
        write_reg(8'h6A, 8'h01);
        write_reg(8'h6B, 8'h02);
        write_reg(8'h6C, 8'h03);
        while (!up_rr_op && n < 300) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 300) begin bad++; $display("FAIL inflight_wait: got no rr strobe, required rr"); end
        rst_n = 1'b0;
        #1;
        total++; if (vec !== 11'b0)  begin bad++; $display("FAIL inflight_strobes: got %h, required 000", vec); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL inflight_busy: got %b, required 0", busy); end
        total++; if (slot !== 5'd0)  begin bad++; $display("FAIL inflight_slot: got %0d, required 0", slot); end
        total++; if (full !== 1'b0)  begin bad++; $display("FAIL inflight_full: got %b, required 0", full); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(200);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL inflight_after: got busy=%b, required 0", busy); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_issue_timing();
        test_low_addr();
        test_burst();
        test_wrap();
        test_zero_resync();
        test_cen_hold();
        test_back_to_back();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
